fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction fetch front-end for the 16-bit core.
- Fetches sequential instruction words from memory with a req/ack handshake and buffers them in a DEPTH-entry FIFO.
- Presents the head word and the following word to the decoder, which retires 0, 1 or 2 words per cycle.
- Sits between the memory port and the decoder. Takes PC redirects from the ALU result bus and flushes stale words, including a response still in flight.

Parameters:
- DATA_W, 16: instruction word width.
- ADDR_W, 16: byte address width. Words are 2-byte aligned, so bit 0 of every address is 0.
- DEPTH, 4: FIFO entries. Power of two, minimum 2.
- RESET_PC, 16'h0000: fetch address after reset.

Ports:
- clk  in  1  clock.
- a_rst  in  1  reset, asynchronous, active-low.
- mem_req  out  1  fetch request; held high until acknowledged.
- mem_addr  out  ADDR_W  fetch address; stable while mem_req is high.
- mem_ack  in  1  memory accepts the request and returns mem_data this cycle.
- mem_data  in  DATA_W  fetched word; valid when mem_ack=1.
- redirect  in  1  load a new PC (taken branch, jump, interrupt).
- redirect_pc  in  ADDR_W  new PC; bit 0 is ignored.
- hold  in  1  decoder stall; blocks pops only.
- consume  in  2  words retired this cycle: 0, 1 or 2. Value 3 is treated as 2.
- pc_out  out  ADDR_W  byte address of the head word.
- ir_out  out  DATA_W  head word.
- k16_out  out  DATA_W  word after the head.
- ir_valid  out  1  count >= 1.
- k_valid  out  1  count >= 2.
- count  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (asynchronous, any cycle, including mid-transaction):
  - count=0, state=RUN, mem_req=0.
  - fetch_addr=RESET_PC, pc_out=RESET_PC.
  - ir_out=0, k16_out=0, ir_valid=0, k_valid=0.
- States:
  - RUN: normal fetching.
  - WAIT: request outstanding; data will be kept.
  - DRAIN: request outstanding; data will be discarded.
- Issue rule: in RUN with count < DEPTH and no redirect, assert mem_req with mem_addr=fetch_addr, then go to WAIT. At most one request is outstanding at any time.
- WAIT with mem_ack:
  - Push mem_data at the tail.
  - fetch_addr += 2, wrapping modulo 2^ADDR_W.
  - Go to RUN. A new request may issue the following cycle.
  - Push latency: the word is visible on ir_out/k16_out the cycle after the ack.
- Overflow: impossible by construction, because issue requires count < DEPTH and only one request is outstanding. Assert this in the bench.
- Pop:
  - When hold=0 and redirect=0, pop n = min(consume, count) words.
  - pc_out += 2*n.
  - Over-consume is clamped silently; no error output.
- A push and a pop in the same cycle are both applied. The new count is count + 1 - n.
- hold=1: no pop, pc_out unchanged. Fetching and pushes continue until the FIFO is full.
- Redirect (highest priority; same-cycle consume and push are ignored):
  - count <= 0.
  - pc_out <= {redirect_pc[ADDR_W-1:1], 0}.
  - fetch_addr <= {redirect_pc[ADDR_W-1:1], 0}.
- Redirect state transitions:
  - From RUN: stay in RUN. Issue at the new address the next cycle.
  - From WAIT without mem_ack: go to DRAIN. mem_req and mem_addr stay unchanged, as the handshake requires.
  - From WAIT with mem_ack in the same cycle: discard the data and go to RUN.
  - From DRAIN: update the target only and stay in DRAIN.
- DRAIN with mem_ack: discard mem_data, leave fetch_addr unchanged, go to RUN.
- Outputs:
  - ir_out/k16_out are the FIFO head and head+1.
  - Read-pointer wrap is modulo DEPTH.
  - When an entry is invalid, its output holds the last value; only the valid flags qualify it.
- Minimum redirect-to-ir_valid latency with single-cycle memory: 3 cycles (issue, ack, visible).

Test Plan:
- Reset, mem_ack tied high the cycle after each mem_req, consume=0 → addresses 0,2,4,6 issued; FIFO fills to count=4; mem_req stays 0 while full; ir_out=word@0, k16_out=word@2.
- Full FIFO, consume=2 for 2 cycles, hold=0 → pc_out steps 0→4→8; count drops to 2 then 0; refetch resumes at address 8.
- Full FIFO, hold=1, consume=2 → count, pc_out and ir_out unchanged for 5 cycles.
- Request to 0x0010 outstanding, redirect_pc=0x0201, ack arrives 3 cycles later → mem_addr stays 0x0010 until ack; the word is dropped; next request goes to 0x0200; pc_out=0x0200; ir_valid=0 until the 0x0200 word lands.
- Redirect and mem_ack in the same cycle → the acked word is not pushed; count=0; next mem_addr is the redirect target.
- count=1, consume=2 → exactly 1 word popped, count=0, pc_out+=2. Also: fetch_addr=0xFFFE with ack → wraps to 0x0000.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Memory port, decoder port and redirect bus of the instruction fetch queue.
// master is the fetch_queue side; slave is the memory/decoder/ALU side.
interface fetch_queue_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_data;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              hold;
   logic [1:0]        consume;
   logic [ADDR_W-1:0] pc_out;
   logic [DATA_W-1:0] ir_out;
   logic [DATA_W-1:0] k16_out;
   logic              ir_valid;
   logic              k_valid;
   logic [CW-1:0]     count;

   modport master (
      output mem_req, mem_addr, pc_out, ir_out, k16_out, ir_valid, k_valid, count,
      input  mem_ack, mem_data, redirect, redirect_pc, hold, consume
   );

   modport slave (
      input  mem_req, mem_addr, pc_out, ir_out, k16_out, ir_valid, k_valid, count,
      output mem_ack, mem_data, redirect, redirect_pc, hold, consume
   );
endinterface

// File: rtl/fetch_queue.sv
// Sequential instruction fetch with a single outstanding req/ack, DEPTH-entry
// word FIFO, 0/1/2-word retire and redirect flush of queued and in-flight words.
module fetch_queue #(
   parameter int                 DATA_W   = 16,
   parameter int                 ADDR_W   = 16,
   parameter int                 DEPTH    = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic          clk,
   input  logic          a_rst,
   fetch_queue_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {S_RUN, S_WAIT, S_DRAIN} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] fetch_q, fetch_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [PW-1:0]     rd_q, rd_d;
   logic [PW-1:0]     wr_q, wr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              issue;
   logic              push;
   logic              req;
   logic [1:0]        want;
   logic [CW-1:0]     pop_n;
   logic [ADDR_W-1:0] target;

   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) state_q <= S_RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      unique case (state_q)
         S_RUN: begin
            if (!bus.redirect && (cnt_q < CW'(DEPTH))) begin
               state_d = S_WAIT;
               issue   = 1'b1;
            end
         end
         S_WAIT: begin
            if (bus.mem_ack)       state_d = S_RUN;
            else if (bus.redirect) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (bus.mem_ack) state_d = S_RUN;
         end
         default: state_d = S_RUN;
      endcase
   end

   // A word is kept only if the request was not overtaken by a redirect.
   always_comb begin
      req  = (state_q != S_RUN);
      push = (state_q == S_WAIT) && bus.mem_ack && !bus.redirect;
   end

   always_comb begin
      target     = bus.redirect_pc & ~ADDR_W'(1);
      want       = (bus.consume == 2'd3) ? 2'd2 : bus.consume;
      pop_n      = '0;
      if (!bus.hold && !bus.redirect)
         pop_n = (cnt_q >= CW'(want)) ? CW'(want) : cnt_q;

      fetch_d    = fetch_q;
      req_addr_d = issue ? fetch_q : req_addr_q;
      pc_d       = pc_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      cnt_d      = cnt_q;

      if (bus.redirect) begin
         // Collapsing the write pointer onto the read pointer keeps the
         // presented words stable while the queue is empty.
         cnt_d   = '0;
         wr_d    = rd_q;
         pc_d    = target;
         fetch_d = target;
      end else begin
         cnt_d = cnt_q + CW'(push) - pop_n;
         rd_d  = rd_q + PW'(pop_n);
         pc_d  = pc_q + (ADDR_W'(pop_n) << 1);
         if (push) begin
            wr_d    = wr_q + PW'(1);
            fetch_d = fetch_q + ADDR_W'(2);
         end
      end
   end

   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) begin
         fetch_q    <= RESET_PC;
         req_addr_q <= RESET_PC;
         pc_q       <= RESET_PC;
         rd_q       <= '0;
         wr_q       <= '0;
         cnt_q      <= '0;
      end else begin
         fetch_q    <= fetch_d;
         req_addr_q <= req_addr_d;
         pc_q       <= pc_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         cnt_q      <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_q] <= bus.mem_data;
      end
   end

   assign bus.mem_req  = req;
   assign bus.mem_addr = req_addr_q;
   assign bus.pc_out   = pc_q;
   assign bus.ir_out   = mem_q[rd_q];
   assign bus.k16_out  = mem_q[rd_q + PW'(1)];
   assign bus.ir_valid = (cnt_q != '0);
   assign bus.k_valid  = (cnt_q >= CW'(2));
   assign bus.count    = cnt_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_queue;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic a_rst;
   always #5 clk = ~clk;

   fetch_queue_if #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH)) bus ();

   fetch_queue #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
      .clk   (clk),
      .a_rst (a_rst),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hC0DE;
   endfunction

   // Reference model: queue of fetched words plus the one in-flight request.
   logic [15:0] q[$];
   bit          m_os, m_keep;
   logic [15:0] m_pc, m_fetch, m_req_addr;

   function automatic void model_reset();
      q.delete();
      m_os = 0; m_keep = 0;
      m_pc = 16'h0000; m_fetch = 16'h0000; m_req_addr = 16'h0000;
   endfunction

   always @(posedge clk) begin
      int n, w, pre;
      if (!a_rst) begin
         model_reset();
      end else begin
         pre = q.size();
         n = 0;
         if (!bus.hold && !bus.redirect) begin
            w = (bus.consume == 2'd3) ? 2 : int'(bus.consume);
            n = (w < pre) ? w : pre;
         end
         for (int i = 0; i < n; i++) void'(q.pop_front());
         m_pc = m_pc + 16'(2 * n);
         if (m_os) begin
            if (bus.mem_ack) begin
               m_os = 0;
               if (m_keep && !bus.redirect) begin
                  chk("no_overflow", 32'(pre < DEPTH), 32'd1);
                  q.push_back(word(m_req_addr));
                  m_fetch = m_fetch + 16'd2;
               end
            end else if (bus.redirect) begin
               m_keep = 0;
            end
         end else if (!bus.redirect && pre < DEPTH) begin
            m_os = 1; m_keep = 1; m_req_addr = m_fetch;
         end
         if (bus.redirect) begin
            q.delete();
            m_pc    = bus.redirect_pc & 16'hFFFE;
            m_fetch = bus.redirect_pc & 16'hFFFE;
         end
      end
   end

   always @(negedge clk) begin
      chk("mem_req", 32'(bus.mem_req), 32'(m_os));
      if (m_os) chk("mem_addr", 32'(bus.mem_addr), 32'(m_req_addr));
      chk("count", 32'(bus.count), 32'(q.size()));
      chk("ir_valid", 32'(bus.ir_valid), 32'(q.size() >= 1));
      chk("k_valid", 32'(bus.k_valid), 32'(q.size() >= 2));
      chk("pc_out", 32'(bus.pc_out), 32'(m_pc));
      if (q.size() >= 1) chk("ir_out", 32'(bus.ir_out), 32'(q[0]));
      if (q.size() >= 2) chk("k16_out", 32'(bus.k16_out), 32'(q[1]));
   end

   // Memory responder: acks after a fixed or random number of cycles.
   int ack_delay = 0;
   bit rand_ack  = 0;
   bit in_req    = 0;
   int wcnt      = 0;
   int cur_delay = 0;

   always @(negedge clk) begin
      if (bus.mem_req && a_rst) begin
         if (!in_req) begin
            in_req    = 1;
            wcnt      = 0;
            cur_delay = rand_ack ? int'($urandom_range(0, 3)) : ack_delay;
         end
         if (wcnt >= cur_delay) begin
            bus.mem_ack  = 1'b1;
            bus.mem_data = word(bus.mem_addr);
         end else begin
            bus.mem_ack  = 1'b0;
            bus.mem_data = 16'($urandom);
            wcnt++;
         end
      end else begin
         bus.mem_ack  = 1'b0;
         bus.mem_data = 16'($urandom);
         in_req       = 0;
      end
   end

   task automatic wait_req(input string nm);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.mem_req) return;
      end
      chk({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_count(input string nm, input int c);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (int'(bus.count) == c) return;
      end
      chk({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      a_rst = 1'b0;
      bus.redirect = 1'b0; bus.redirect_pc = 16'h0000;
      bus.hold = 1'b0; bus.consume = 2'd0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_req", 32'(bus.mem_req), 32'd0);
      chk("rst_pc", 32'(bus.pc_out), 32'h0000);
      chk("rst_ir", 32'(bus.ir_out), 32'h0000);
      chk("rst_k16", 32'(bus.k16_out), 32'h0000);
      chk("rst_valids", {30'd0, bus.ir_valid, bus.k_valid}, 32'd0);
      a_rst = 1'b1;

      // Fill from reset with single-cycle memory.
      repeat (12) @(negedge clk);
      chk("fill_count", 32'(bus.count), 32'd4);
      chk("fill_req", 32'(bus.mem_req), 32'd0);
      chk("fill_ir", 32'(bus.ir_out), 32'h0000C0DE);
      chk("fill_k16", 32'(bus.k16_out), 32'h0000C2DE);

      // Drain two words per cycle.
      bus.consume = 2'd2;
      @(negedge clk);
      chk("pop1_pc", 32'(bus.pc_out), 32'h0004);
      chk("pop1_count", 32'(bus.count), 32'd2);
      @(negedge clk);
      bus.consume = 2'd0;
      chk("pop2_pc", 32'(bus.pc_out), 32'h0008);
      chk("pop2_count", 32'(bus.count), 32'd0);
      chk("refetch_addr", 32'(bus.mem_addr), 32'h0008);

      // Hold blocks pops on a full queue.
      repeat (10) @(negedge clk);
      bus.hold = 1'b1; bus.consume = 2'd2;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_count", 32'(bus.count), 32'd4);
         chk("hold_pc", 32'(bus.pc_out), 32'h0008);
         chk("hold_ir", 32'(bus.ir_out), 32'h0000C8DE);
      end
      bus.hold = 1'b0; bus.consume = 2'd0;

      // Redirect while a slow request to 0x0010 is outstanding.
      ack_delay = 3;
      bus.consume = 2'd2;
      @(negedge clk);
      bus.consume = 2'd0;
      wait_req("req10");
      chk("drain_addr0", 32'(bus.mem_addr), 32'h0010);
      bus.redirect = 1'b1; bus.redirect_pc = 16'h0201;
      @(negedge clk);
      bus.redirect = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         chk("drain_req", 32'(bus.mem_req), 32'd1);
         chk("drain_addr", 32'(bus.mem_addr), 32'h0010);
         chk("drain_pc", 32'(bus.pc_out), 32'h0200);
         chk("drain_irv", 32'(bus.ir_valid), 32'd0);
      end
      @(negedge clk);
      chk("drain_done_req", 32'(bus.mem_req), 32'd0);
      chk("drain_done_cnt", 32'(bus.count), 32'd0);
      wait_req("req200");
      chk("redir_addr", 32'(bus.mem_addr), 32'h0200);
      wait_count("land200", 1);
      chk("redir_ir", 32'(bus.ir_out), 32'h0000C0DC);

      // Redirect coinciding with an ack drops the acked word.
      ack_delay = 0;
      wait_req("req202");
      bus.redirect = 1'b1; bus.redirect_pc = 16'h0300;
      @(negedge clk);
      bus.redirect = 1'b0;
      chk("same_cnt", 32'(bus.count), 32'd0);
      chk("same_req", 32'(bus.mem_req), 32'd0);
      @(negedge clk);
      chk("same_next_req", 32'(bus.mem_req), 32'd1);
      chk("same_next_addr", 32'(bus.mem_addr), 32'h0300);

      // Over-consume on a single entry.
      wait_count("land300", 1);
      bus.consume = 2'd2;
      @(negedge clk);
      bus.consume = 2'd0;
      chk("clamp_cnt", 32'(bus.count), 32'd0);
      chk("clamp_pc", 32'(bus.pc_out), 32'h0302);

      // Fetch address wraps past 0xFFFE.
      @(negedge clk);
      bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFF;
      @(negedge clk);
      bus.redirect = 1'b0;
      wait_count("landFFFE", 1);
      chk("wrap_pc", 32'(bus.pc_out), 32'hFFFE);
      chk("wrap_ir", 32'(bus.ir_out), 32'h00003E21);
      wait_req("req0000");
      chk("wrap_addr", 32'(bus.mem_addr), 32'h0000);

      // Randomized traffic with one asynchronous reset mid-request.
      rand_ack = 1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (i == 1500) begin
            bus.redirect = 1'b0; bus.hold = 1'b0; bus.consume = 2'd0;
            wait_req("mid_rst_req");
            #2 a_rst = 1'b0;
            #1;
            chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
            chk("mid_rst_cnt", 32'(bus.count), 32'd0);
            chk("mid_rst_pc", 32'(bus.pc_out), 32'h0000);
            chk("mid_rst_ir", 32'(bus.ir_out), 32'h0000);
            model_reset();
            @(negedge clk);
            a_rst = 1'b1;
         end else begin
            bus.redirect    = ($urandom_range(0, 99) < 5);
            bus.redirect_pc = 16'($urandom);
            bus.hold        = ($urandom_range(0, 99) < 20);
            bus.consume     = 2'($urandom_range(0, 3));
         end
      end
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
